iter_divider: RTL and testbench

Iterative radix-2 restoring divider; the inverse-operation companion to the pipelined Booth multiplier in the arithmetic datapath. It accepts a dividend/divisor pair over the same valid/ready handshake and returns quotient and remainder. Signed and unsigned operation is selected per request, with fixed latency. The block is one operation in flight, not pipelined, and sits alongside the multiplier behind the execute-stage issue logic.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_step.sv | 21 ++
 rtl/iter_divider.sv | 120 ++++++++++++
 tb/tb_iter_divider.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Iteration counter width: enough to hold WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational radix-2 restoring division step on operand magnitudes.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted  = {partial_rem, dividend_bit};
    quot_bit = (shifted >= {1'b0, divisor});
    // A successful trial always fits in WIDTH bits because partial_rem < divisor.
    next_rem = quot_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative signed/unsigned restoring divider, one operation in flight,
// fixed latency WIDTH+1 from accept to valid_o, valid/ready on both sides.
module iter_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             signed_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned      CW  = cnt_w(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e state, state_nxt;

  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, dz, ovf;
  logic             accept;
  logic [WIDTH-1:0] mag1, mag2;
  logic [WIDTH-1:0] q_fix, r_fix;

  div_step #(.WIDTH(WIDTH)) u_step (
    .partial_rem  (prem),
    .dividend_bit (dq[WIDTH-1]),
    .divisor      (divisor_r),
    .next_rem     (step_rem),
    .quot_bit     (step_q)
  );

  always_comb begin
    ready_o = (state == IDLE) || ((state == DONE) && ready_i);
    accept  = valid_i && ready_o;
    mag1    = (signed_i && data1[WIDTH-1]) ? ('0 - data1) : data1;
    mag2    = (signed_i && data2[WIDTH-1]) ? ('0 - data2) : data2;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = ITER;
      ITER: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (ready_i) state_nxt = valid_i ? ITER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Divide-by-zero remainder needs no override: with a zero divisor every trial
  // succeeds, so the magnitude passes through and sign correction restores data1.
  always_comb begin
    q_fix = neg_q ? ('0 - dq) : dq;
    r_fix = neg_r ? ('0 - prem) : prem;
    if (dz) q_fix = '1;
    if (ovf) begin
      q_fix = MIN;
      r_fix = '0;
    end
  end

  // dq starts as the dividend and fills with quotient bits as it shifts left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq        <= '0;
      prem      <= '0;
      divisor_r <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      valid_o   <= 1'b0;
    end else begin
      if (accept) begin
        dq        <= mag1;
        prem      <= '0;
        divisor_r <= mag2;
        cnt       <= CW'(WIDTH - 1);
        neg_q     <= signed_i && (data1[WIDTH-1] ^ data2[WIDTH-1]);
        neg_r     <= signed_i && data1[WIDTH-1];
        dz        <= (data2 == '0);
        ovf       <= signed_i && (data1 == MIN) && (data2 == '1);
      end else if (state == ITER) begin
        dq   <= {dq[WIDTH-2:0], step_q};
        prem <= step_rem;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end

      if (state == FIX) begin
        quot    <= q_fix;
        rem     <= r_fix;
        valid_o <= 1'b1;
      end else if ((state == DONE) && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider: directed cases, backpressure, reset, random.
module tb_iter_divider;

  localparam int unsigned   WIDTH = 32;
  localparam logic [31:0]   MIN   = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [WIDTH-1:0]  data1 = '0;
  logic [WIDTH-1:0]  data2 = '0;
  logic              signed_i = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_o;
  logic              ready_i = 1'b1;
  logic              valid_o;
  logic [WIDTH-1:0]  quot;
  logic [WIDTH-1:0]  rem;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] sb[$];
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        prev_v = 1'b0;
  bit          rnd_done = 1'b0;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data1    (data1),
    .data2    (data2),
    .signed_i (signed_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ready_i  (ready_i),
    .valid_o  (valid_o),
    .quot     (quot),
    .rem      (rem)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // RISC-V DIV/DIVU/REM/REMU semantics, returned as {quot, rem}.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint      sa, sbv, q, r;
    logic [63:0] qq, rr;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s && a == MIN && b == 32'hFFFF_FFFF) return {MIN, 32'd0};
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      qq  = q;
      rr  = r;
      return {qq[31:0], rr[31:0]};
    end
    return {a / b, a % b};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on accept, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      if (valid_o && !prev_v) begin
        check_eq("latency", 64'(cyc - acc_cyc), 64'(WIDTH + 1));
        check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      end
      if (valid_o && ready_i && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("quot", 64'(quot), 64'(e[63:32]));
        check_eq("rem",  64'(rem),  64'(e[31:0]));
      end
      if (valid_i && ready_o) begin
        sb.push_back(ref_div(data1, data2, signed_i));
        acc_cyc = cyc + 1;
      end
    end
    prev_v = valid_o;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [31:0] d1, input logic [31:0] d2, input logic s);
    bit done = 1'b0;
    data1    = d1;
    data2    = d2;
    signed_i = s;
    valid_i  = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data1    = $urandom;
        data2    = $urandom;
        signed_i = $urandom_range(0, 1);
        done = 1'b1;
      end
    end
    valid_i = 1'b0;
    check_eq("accept", 64'(done), 64'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq("drain", 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return MIN;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int vh;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", 64'(valid_o), 64'd0);
    check_eq("rst_quot",  64'(quot),    64'd0);
    check_eq("rst_rem",   64'(rem),     64'd0);
    check_eq("rst_ready", 64'(ready_o), 64'd1);
    rst_n = 1'b1;
    step(2);

    issue(32'd100, 32'd7, 1'b0);
    wait_drain();
    step(1);
    check_eq("one_cycle_valid", 64'(valid_o), 64'd0);

    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_drain();
    step(1);
    issue(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_drain();
    step(1);
    issue(32'd5, 32'd0, 1'b0);
    wait_drain();
    step(1);
    issue(32'd5, 32'd0, 1'b1);
    wait_drain();
    step(1);
    issue(MIN, 32'hFFFF_FFFF, 1'b1);
    wait_drain();
    step(1);

    // Backpressure: result held while ready_i=0, second request waits for ready_i.
    ready_i = 1'b0;
    issue(32'd20, 32'd3, 1'b0);
    for (int k = 0; k < 100 && !valid_o; k++) @(negedge clk);
    #1;
    data1 = 32'd50; data2 = 32'd6; signed_i = 1'b0; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check_eq("bp_valid", 64'(valid_o), 64'd1);
      check_eq("bp_quot",  64'(quot),    64'd6);
      check_eq("bp_rem",   64'(rem),     64'd2);
      check_eq("bp_ready", 64'(ready_o), 64'd0);
    end
    @(posedge clk);
    #1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check_eq("bp_drop",   64'(valid_o), 64'd0);
    check_eq("bp_taken",  64'(ready_o), 64'd0);
    check_eq("bp_queued", 64'(sb.size()), 64'd1);
    wait_drain();
    step(1);

    // Reset in the middle of an iteration sequence.
    issue(32'd1000, 32'd3, 1'b0);
    step(9);
    rst_n = 1'b0;
    sb.delete();
    step(2);
    rst_n = 1'b1;
    step(1);
    check_eq("mid_rst_valid", 64'(valid_o), 64'd0);
    check_eq("mid_rst_quot",  64'(quot),    64'd0);
    check_eq("mid_rst_rem",   64'(rem),     64'd0);
    check_eq("mid_rst_ready", 64'(ready_o), 64'd1);
    vh = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_o) vh++;
    end
    check_eq("no_ghost_valid", 64'(vh), 64'd0);
    step(1);
    issue(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_drain();
    check_eq("post_rst_quot", 64'(quot), 64'h0FFF_FFFF);
    check_eq("post_rst_rem",  64'(rem),  64'hF);
    step(1);

    fork
      begin
        for (int i = 0; i < 1200; i++) begin
          step($urandom_range(0, 2));
          issue(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    wait_drain();
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
